data_bus_latch: RTL and testbench

Input data latch and data output register between the external memory data pins and the internal buses. It sequences one memory cycle at a time: setup, then wait-for-ready, then capture or drive. A captured read byte is held and driven onto exactly one internal bus (DB, ADL or ADH) until the consuming stage releases it. The DB/ADH values it produces are what the pass-transistor bridges to the special bus then carry onward.

---
 rtl/dl_pkg.sv | 32 +++
 rtl/dl_wait_timer.sv | 39 +++
 rtl/data_bus_latch.sv | 161 ++++++++++++++++
 tb/tb_data_bus_latch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// Shared types and constants for the data bus latch.
// Optional build macro: DL_ADH_DRIVE_EN enables holding a read byte for the ADH bus.
package dl_pkg;

  // Memory cycle sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWait,
    StHold
  } dl_state_e;

  // Read destination codes, as presented on dst_sel.
  localparam logic [1:0] DST_DB   = 2'b00;
  localparam logic [1:0] DST_ADL  = 2'b01;
  localparam logic [1:0] DST_ADH  = 2'b10;
  localparam logic [1:0] DST_NONE = 2'b11;

  // Value seen on the data pins when nothing drives them.
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // True when a completed read to this destination must be held for a consumer.
  function automatic logic dst_holds(input logic [1:0] dst);
`ifdef DL_ADH_DRIVE_EN
    return dst != DST_NONE;
`else
    // Without the ADH drive path an ADH read behaves like a read to nowhere.
    return (dst != DST_NONE) && (dst != DST_ADH);
`endif
  endfunction

endpackage

// File: rtl/dl_wait_timer.sv
// Counts consecutive not-ready WAIT cycles; flags expiry when the count reaches WAIT_MAX.
module dl_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  // At least one bit even when WAIT_MAX is zero.
  localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_MAX);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CntMax);

  // Next count: clear wins; increments stop at the limit so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_bus_latch.sv
// Data latch (DL) and data output register (DOR) between external data pins and internal buses.
// Sequences one memory cycle at a time: SETUP, WAIT for rdy, then capture/drive.
// A captured read byte is held on one internal bus until the consumer releases it.
// Optional build macro: DL_ADH_DRIVE_EN (hold and drive ADH for dst_sel=10).
// The consumer release input is named hold_release because "release" is reserved.
module data_bus_latch
  import dl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cyc_req,
  input  logic       cyc_rw,
  input  logic [1:0] dst_sel,
  input  logic [7:0] wr_data,
  input  logic       rdy,
  input  logic [7:0] ext_din,
  output logic [7:0] ext_dout,
  output logic       ext_oe,
  output logic [7:0] dl_q,
  output logic       db_oe,
  output logic       adl_oe,
  output logic       adh_oe,
  input  logic       hold_release,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  dl_state_e  state_q, state_d;
  logic       rw_q, rw_d;
  logic [1:0] dst_q, dst_d;
  logic [7:0] dl_d;
  logic [7:0] dor_q, dor_d;
  logic       timeout_q, timeout_d;
  logic       done_q, done_d;

  logic       tmr_clear;
  logic       tmr_tick;
  logic       tmr_expired;

  dl_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  // Next-state logic for the cycle sequencer, DL, DOR and status flags.
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    dst_d     = dst_q;
    dl_d      = dl_q;
    dor_d     = dor_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    tmr_clear = 1'b0;
    tmr_tick  = 1'b0;

    case (state_q)
      StIdle: begin
        if (cyc_req) begin
          state_d   = StSetup;
          rw_d      = cyc_rw;
          dst_d     = dst_sel;
          timeout_d = 1'b0;
          tmr_clear = 1'b1;
          if (!cyc_rw) begin
            dor_d = wr_data;
          end
        end
      end

      StSetup: begin
        state_d = StWait;
      end

      StWait: begin
        // rdy is checked first so a ready memory on the last allowed cycle never times out.
        if (rdy) begin
          if (rw_q) begin
            dl_d = ext_din;
            if (dst_holds(dst_q)) begin
              state_d = StHold;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
          done_d    = 1'b1;
          if (rw_q) begin
            dl_d = OPEN_BUS;
          end
        end else begin
          tmr_tick = 1'b1;
        end
      end

      StHold: begin
        // A cyc_req in this same cycle is dropped; the requester must retry from IDLE.
        if (hold_release) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset drops every enable and suppresses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rw_q      <= 1'b0;
      dst_q     <= DST_NONE;
      dl_q      <= 8'h00;
      dor_q     <= 8'h00;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      dst_q     <= dst_d;
      dl_q      <= dl_d;
      dor_q     <= dor_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    ext_dout = dor_q;
    ext_oe   = !rw_q && ((state_q == StSetup) || (state_q == StWait));
    busy     = (state_q != StIdle);
    done     = done_q;
    timeout  = timeout_q;
    db_oe    = (state_q == StHold) && (dst_q == DST_DB);
    adl_oe   = (state_q == StHold) && (dst_q == DST_ADL);
`ifdef DL_ADH_DRIVE_EN
    adh_oe   = (state_q == StHold) && (dst_q == DST_ADH);
`else
    adh_oe   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_data_bus_latch.sv
// Scoreboard bench for data_bus_latch: stimulus pushes the expected completion,
// a monitor pops and compares on every done pulse.
module tb_data_bus_latch;
  import dl_pkg::*;

  localparam int unsigned WaitMax = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cyc_req;
  logic       cyc_rw;
  logic [1:0] dst_sel;
  logic [7:0] wr_data;
  logic       rdy;
  logic [7:0] ext_din;
  logic [7:0] ext_dout;
  logic       ext_oe;
  logic [7:0] dl_q;
  logic       db_oe;
  logic       adl_oe;
  logic       adh_oe;
  logic       hold_release;
  logic       busy;
  logic       done;
  logic       timeout;

  always #5 clk = ~clk;

  data_bus_latch #(
    .WAIT_MAX (WaitMax)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cyc_req      (cyc_req),
    .cyc_rw       (cyc_rw),
    .dst_sel      (dst_sel),
    .wr_data      (wr_data),
    .rdy          (rdy),
    .ext_din      (ext_din),
    .ext_dout     (ext_dout),
    .ext_oe       (ext_oe),
    .dl_q         (dl_q),
    .db_oe        (db_oe),
    .adl_oe       (adl_oe),
    .adh_oe       (adh_oe),
    .hold_release (hold_release),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
  );

  typedef struct {
    logic [7:0] dl;
    logic [7:0] dout;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic push(input logic [7:0] dl, input logic [7:0] dout, input logic to);
    exp_t e;
    e.dl   = dl;
    e.dout = dout;
    e.to   = to;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic rw, input logic [1:0] dst, input logic [7:0] data);
    cyc_req = 1'b1;
    cyc_rw  = rw;
    dst_sel = dst;
    wr_data = data;
    tick();
    cyc_req = 1'b0;
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done=1, want no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_dl_q", dl_q, e.dl);
        chk("done_ext_dout", ext_dout, e.dout);
        chk("done_timeout", timeout, e.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_cnt;
    int busy_cnt;

    rst_n        = 1'b0;
    cyc_req      = 1'b0;
    cyc_rw       = 1'b0;
    dst_sel      = DST_NONE;
    wr_data      = 8'h00;
    rdy          = 1'b0;
    ext_din      = 8'h00;
    hold_release = 1'b0;
    #3;
    chk("rst_dl_q", dl_q, 8'h00);
    chk("rst_ext_dout", ext_dout, 8'h00);
    chk("rst_ext_oe", ext_oe, 1'b0);
    chk("rst_bus_oe", {db_oe, adl_oe, adh_oe}, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    #9;
    rst_n = 1'b1;
    tick();

    // Read 3C to DB, memory ready at once; release in cycle 5.
    rdy     = 1'b1;
    ext_din = 8'h3C;
    push(8'h3C, 8'h00, 1'b0);
    start(1'b1, DST_DB, 8'h00);
    chk("rd_c1_busy", busy, 1'b1);
    chk("rd_c1_ext_oe", ext_oe, 1'b0);
    tick();
    chk("rd_c2_db_oe", db_oe, 1'b0);
    tick();
    chk("rd_c3_dl_q", dl_q, 8'h3C);
    chk("rd_c3_db_oe", db_oe, 1'b1);
    tick();
    chk("rd_c4_db_oe", db_oe, 1'b1);
    tick();
    hold_release = 1'b1;
    tick();
    hold_release = 1'b0;
    chk("rd_c6_done", done, 1'b1);
    chk("rd_c6_db_oe", db_oe, 1'b0);
    chk("rd_c6_busy", busy, 1'b0);

    // Write A5; rdy rises on the WAIT cycle where cnt == WAIT_MAX, so no timeout.
    rdy = 1'b0;
    push(8'h3C, 8'hA5, 1'b0);
    start(1'b0, DST_NONE, 8'hA5);
    chk("wr_c1_ext_dout", ext_dout, 8'hA5);
    oe_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (ext_oe) oe_cnt++;
      if (i == 4) rdy = 1'b1;
      tick();
    end
    chk("wr_oe_cycles", oe_cnt, 5);
    chk("wr_timeout", timeout, 1'b0);

    // Read with rdy stuck low: SETUP + 4 WAIT cycles, then open-bus timeout.
    rdy     = 1'b0;
    ext_din = 8'h5A;
    push(8'hFF, 8'hA5, 1'b1);
    start(1'b1, DST_DB, 8'h00);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cnt++;
      tick();
    end
    chk("to_busy_cycles", busy_cnt, 5);
    chk("to_timeout", timeout, 1'b1);
    chk("to_dl_q", dl_q, 8'hFF);

    // Read to nowhere clears timeout and completes straight from capture.
    rdy     = 1'b1;
    ext_din = 8'hC3;
    push(8'hC3, 8'hA5, 1'b0);
    start(1'b1, DST_NONE, 8'h00);
    chk("none_to_clear", timeout, 1'b0);
    tick();
    tick();
    chk("none_c3_busy", busy, 1'b0);
    chk("none_c3_done", done, 1'b1);
    chk("none_c3_bus_oe", {db_oe, adl_oe, adh_oe}, 3'b000);

    // ADL read with rdy on the last allowed cycle; requests during HOLD are dropped.
    rdy     = 1'b0;
    ext_din = 8'h96;
    push(8'h96, 8'hA5, 1'b0);
    start(1'b1, DST_ADL, 8'h00);
    tick();
    tick();
    tick();
    tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("adl_hold_oe", adl_oe, 1'b1);
    chk("adl_dl_q", dl_q, 8'h96);
    chk("adl_timeout", timeout, 1'b0);
    cyc_req = 1'b1;
    cyc_rw  = 1'b0;
    wr_data = 8'hEE;
    tick();
    cyc_req = 1'b0;
    chk("hold_req_busy", busy, 1'b1);
    chk("hold_req_dout", ext_dout, 8'hA5);
    chk("hold_req_adl_oe", adl_oe, 1'b1);
    hold_release = 1'b1;
    cyc_req      = 1'b1;
    wr_data      = 8'h11;
    tick();
    hold_release = 1'b0;
    cyc_req      = 1'b0;
    chk("rel_req_busy", busy, 1'b0);
    chk("rel_req_dout", ext_dout, 8'hA5);
    chk("rel_adl_oe", adl_oe, 1'b0);
    tick();
    chk("rel_req_not_queued", busy, 1'b0);

    // ADH read: held only when the ADH drive path is built in.
    rdy     = 1'b1;
    ext_din = 8'h7E;
    push(8'h7E, 8'hA5, 1'b0);
    start(1'b1, DST_ADH, 8'h00);
    tick();
    tick();
    chk("adh_dl_q", dl_q, 8'h7E);
`ifdef DL_ADH_DRIVE_EN
    chk("adh_oe_hold", adh_oe, 1'b1);
    chk("adh_busy", busy, 1'b1);
    tick();
    chk("adh_oe_c4", adh_oe, 1'b1);
    hold_release = 1'b1;
    tick();
    hold_release = 1'b0;
    chk("adh_oe_released", adh_oe, 1'b0);
    chk("adh_done", done, 1'b1);
`else
    chk("adh_oe_tied", adh_oe, 1'b0);
    chk("adh_busy", busy, 1'b0);
    chk("adh_done", done, 1'b1);
`endif
    tick();

    // Asynchronous reset in the middle of a write WAIT cycle.
    rdy = 1'b0;
    start(1'b0, DST_NONE, 8'h5C);
    chk("rstw_c1_ext_oe", ext_oe, 1'b1);
    tick();
    chk("rstw_c2_ext_oe", ext_oe, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstw_ext_oe", ext_oe, 1'b0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_ext_dout", ext_dout, 8'h00);
    chk("rstw_dl_q", dl_q, 8'h00);
    chk("rstw_done", done, 1'b0);
    chk("rstw_timeout", timeout, 1'b0);
    chk("rstw_bus_oe", {db_oe, adl_oe, adh_oe}, 3'b000);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_done", done, 1'b0);
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
